// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port dmem arbiter: owner state encoding and port indices.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a tie goes to the port that is not `last`.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req[1] && req[0]) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the CPU (port 0) and a secondary master (port 1) on one dmem.
// Optional alignment checking (err0/err1 outputs) when DMEM_ARB_ALIGN_CHECK_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned Nloc     = 64,
    parameter int unsigned Dbits    = 32,
    parameter int unsigned MAXBURST = 4,
    localparam int unsigned AW      = $clog2(Nloc) + 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic             wr0,
    input  logic             wr1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [Dbits-1:0] wdata0,
    input  logic [Dbits-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [Dbits-1:0] rdata0,
    output logic [Dbits-1:0] rdata1,
    output logic             rvalid0,
    output logic             rvalid1,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    output logic             err0,
    output logic             err1,
`endif
    output logic             mem_wr,
    output logic [AW-1:0]    mem_addr,
    output logic [Dbits-1:0] mem_din,
    input  logic [Dbits-1:0] mem_dout
);

    localparam int unsigned CW = $clog2(MAXBURST + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAXBURST - 1);

    arb_state_t    owner, owner_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] burst_cnt, cnt_nxt;

    logic [1:0] pick_req;
    logic       pick_last;
    logic       pick_win;
    logic       pick_valid;
    logic       sat;
    logic       cur;
    logic       sel1;
    logic       ok0, ok1;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign ok0 = (addr0[1:0] == 2'b00);
    assign ok1 = (addr1[1:0] == 2'b00);
`else
    assign ok0 = 1'b1;
    assign ok1 = 1'b1;
`endif

    assign gnt0   = (owner == OWN0) & req0;
    assign gnt1   = (owner == OWN1) & req1;
    assign mem_wr = (gnt0 & wr0 & ok0) | (gnt1 & wr1 & ok1);
    assign sat    = (burst_cnt == CNT_SAT);

    // Idle bus follows the last owner so the address lines stay quiet between accesses.
    always_comb begin
        sel1 = last;
        if (owner == OWN0) begin
            sel1 = 1'b0;
        end else if (owner == OWN1) begin
            sel1 = 1'b1;
        end
    end

    assign mem_addr = sel1 ? addr1  : addr0;
    assign mem_din  = sel1 ? wdata1 : wdata0;

    // While owning, the owner's request is masked when it must yield, and ties favour the owner.
    always_comb begin
        pick_req  = {req1, req0};
        pick_last = last;
        case (owner)
            OWN0: begin
                pick_req  = {req1, req0 & ~(req1 & (~lock0 | sat))};
                pick_last = 1'b1;
            end
            OWN1: begin
                pick_req  = {req1 & ~(req0 & (~lock1 | sat)), req0};
                pick_last = 1'b0;
            end
            default: ;
        endcase
    end

    rr_pick2 u_pick (
        .req    (pick_req),
        .last   (pick_last),
        .winner (pick_win),
        .valid  (pick_valid)
    );

    // Next-state: stay and count, hand over, or drop back to IDLE.
    always_comb begin
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = burst_cnt;
        cur       = (owner == OWN1) ? 1'(P1) : 1'(P0);
        case (owner)
            OWN0, OWN1: begin
                if (pick_valid && (pick_win == cur)) begin
                    cnt_nxt = sat ? burst_cnt : burst_cnt + CW'(1);
                end else begin
                    owner_nxt = pick_valid ? (pick_win ? OWN1 : OWN0) : IDLE;
                    cnt_nxt   = '0;
                    last_nxt  = cur;
                end
            end
            default: begin
                owner_nxt = pick_valid ? (pick_win ? OWN1 : OWN0) : IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            owner     <= owner_nxt;
            last      <= last_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    // Read return path, one register stage per port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~wr0 & ok0;
            rvalid1 <= gnt1 & ~wr1 & ok1;
            if (gnt0 & ~wr0 & ok0) begin
                rdata0 <= mem_dout;
            end
            if (gnt1 & ~wr1 & ok1) begin
                rdata1 <= mem_dout;
            end
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err0 <= 1'b0;
            err1 <= 1'b0;
        end else begin
            err0 <= gnt0 & ~ok0;
            err1 <= gnt1 & ~ok1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural dmem; set DMEM_ARB_ALIGN_CHECK_EN to cover err0/err1.
module tb_dmem_arbiter;

    localparam int unsigned NLOC = 64;
    localparam int unsigned DB   = 32;
    localparam int unsigned AW   = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0, req1, lock0, lock1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DB-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_wr;
    logic [DB-1:0] rdata0, rdata1, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic          err0, err1;
`endif

    dmem_arbiter #(.Nloc(NLOC), .Dbits(DB), .MAXBURST(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .lock0   (lock0),
        .lock1   (lock1),
        .wr0     (wr0),
        .wr1     (wr1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        .err0    (err0),
        .err1    (err1),
`endif
        .mem_wr  (mem_wr),
        .mem_addr(mem_addr),
        .mem_din (mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    function automatic logic [DB-1:0] pat(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Behavioural dmem: async read, write on posedge, preloaded on the first edge.
    logic [DB-1:0] dmem [NLOC];
    logic          mem_loaded = 1'b0;
    assign mem_dout = dmem[mem_addr[AW-1:2]];
    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < int'(NLOC); i++) dmem[i] <= pat(i);
            mem_loaded <= 1'b1;
        end else if (mem_wr) begin
            dmem[mem_addr[AW-1:2]] <= mem_din;
        end
    end

    logic [DB-1:0]    ref_mem [NLOC];
    logic [DB-1:0]    exp_rd0[$];
    logic [DB-1:0]    exp_rd1[$];
    logic [AW+DB-1:0] exp_wr[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read response and every memory write is matched against the queues.
    always @(negedge clock) begin
        if (rvalid0) begin
            if (exp_rd0.size() == 0) check("rd0 pending", 64'(exp_rd0.size() != 0), 64'(1));
            else check("rdata0", 64'(rdata0), 64'(exp_rd0.pop_front()));
        end
        if (rvalid1) begin
            if (exp_rd1.size() == 0) check("rd1 pending", 64'(exp_rd1.size() != 0), 64'(1));
            else check("rdata1", 64'(rdata1), 64'(exp_rd1.pop_front()));
        end
        if (mem_wr) begin
            if (exp_wr.size() == 0) check("wr pending", 64'(exp_wr.size() != 0), 64'(1));
            else check("mem write", 64'({mem_addr, mem_din}), 64'(exp_wr.pop_front()));
        end
    end

    // Request attributes must hold while waiting for a grant.
    a_hold0: assert property (@(posedge clock) disable iff (!reset_n)
        (req0 && !gnt0) |=> ($stable(wr0) && $stable(addr0) && $stable(wdata0)));
    a_hold1: assert property (@(posedge clock) disable iff (!reset_n)
        (req1 && !gnt1) |=> ($stable(wr1) && $stable(addr1) && $stable(wdata1)));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; wr0 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        reset_n = 1'b0;
        repeat (2) samp();
        reset_n = 1'b1;
        tick();
    endtask

    logic [1:0] g2 [5];
    logic [1:0] g3 [7];

    initial begin
        for (int i = 0; i < int'(NLOC); i++) ref_mem[i] = pat(i);
        g2 = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        g3 = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

        // Reset values
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; wr0 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) samp();
        check("rst gnt", 64'({gnt1, gnt0}), 64'(0));
        check("rst mem_wr", 64'(mem_wr), 64'(0));
        check("rst rvalid", 64'({rvalid1, rvalid0}), 64'(0));
        check("rst rdata0", 64'(rdata0), 64'(0));
        check("rst rdata1", 64'(rdata1), 64'(0));
        reset_n = 1'b1;
        tick();

        // T1: port 0 write to addr 8, then read it back
        exp_wr.push_back({8'd8, 32'hDEADBEEF});
        ref_mem[2] = 32'hDEADBEEF;
        req0 = 1; wr0 = 1; addr0 = 8'd8; wdata0 = 32'hDEADBEEF;
        samp(); check("t1 gnt0 idle cycle", 64'(gnt0), 64'(0));
        samp(); check("t1 gnt0", 64'(gnt0), 64'(1));
        check("t1 mem_wr", 64'(mem_wr), 64'(1));
        check("t1 mem_addr", 64'(mem_addr), 64'(8));
        tick();
        exp_rd0.push_back(ref_mem[2]);
        wr0 = 0;
        samp(); check("t1 read gnt0", 64'(gnt0), 64'(1));
        check("t1 read mem_wr", 64'(mem_wr), 64'(0));
        tick(); req0 = 0;
        samp(); check("t1 rvalid0", 64'(rvalid0), 64'(1));
        check("t1 rdata0", 64'(rdata0), 64'(32'hDEADBEEF));
        samp(); check("t1 rvalid0 pulse", 64'(rvalid0), 64'(0));
`ifndef DMEM_ARB_ALIGN_CHECK_EN
        // Low address bits are ignored: addr 0x0B reads word 2
        tick();
        exp_rd1.push_back(32'hDEADBEEF);
        req1 = 1; wr1 = 0; addr1 = 8'h0B;
        samp(); check("t1b gnt1 idle cycle", 64'(gnt1), 64'(0));
        samp(); check("t1b gnt1", 64'(gnt1), 64'(1));
        tick(); req1 = 0;
        samp(); check("t1b rvalid1", 64'(rvalid1), 64'(1));
`endif

        // T2: simultaneous unlocked requests alternate, port 0 first
        do_reset();
        repeat (2) exp_rd0.push_back(ref_mem[4]);
        repeat (2) exp_rd1.push_back(ref_mem[5]);
        req0 = 1; addr0 = 8'h10; req1 = 1; addr1 = 8'h14;
        for (int k = 0; k < 5; k++) begin
            samp(); check($sformatf("t2 gnt k=%0d", k), 64'({gnt1, gnt0}), 64'(g2[k]));
            tick();
        end
        req0 = 0; req1 = 0;
        samp(); check("t2 gnt after drop", 64'({gnt1, gnt0}), 64'(0));

        // T3: locked burst on port 0 is cut after MAXBURST grants
        do_reset();
        repeat (5) exp_rd0.push_back(ref_mem[8]);
        exp_rd1.push_back(ref_mem[9]);
        req0 = 1; lock0 = 1; addr0 = 8'h20;
        for (int k = 0; k < 7; k++) begin
            samp(); check($sformatf("t3 gnt k=%0d", k), 64'({gnt1, gnt0}), 64'(g3[k]));
            tick();
            if (k == 0) begin req1 = 1; addr1 = 8'h24; end
            if (k == 5) req1 = 0;
            if (k == 6) begin req0 = 0; lock0 = 0; end
        end
        samp(); check("t3 gnt after drop", 64'({gnt1, gnt0}), 64'(0));

        // T4: sole requester streams at one access per cycle
        do_reset();
        repeat (10) exp_rd1.push_back(ref_mem[12]);
        req1 = 1; addr1 = 8'h30;
        for (int k = 0; k < 11; k++) begin
            samp(); check($sformatf("t4 gnt k=%0d", k), 64'({gnt1, gnt0}), (k == 0) ? 64'(0) : 64'(2));
            tick();
            if (k == 10) req1 = 0;
        end
        samp(); check("t4 gnt after drop", 64'({gnt1, gnt0}), 64'(0));

        // T5: reset during a granted write suppresses it
        do_reset();
        exp_wr.push_back({8'h0C, 32'hCAFEF00D});
        req0 = 1; wr0 = 1; addr0 = 8'h0C; wdata0 = 32'hCAFEF00D;
        samp(); check("t5 gnt0 idle cycle", 64'(gnt0), 64'(0));
        samp(); check("t5 gnt0", 64'(gnt0), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("t5 mem_wr in reset", 64'(mem_wr), 64'(0));
        check("t5 gnt0 in reset", 64'(gnt0), 64'(0));
        check("t5 rvalid in reset", 64'({rvalid1, rvalid0}), 64'(0));
        tick();
        check("t5 word unchanged", 64'(dmem[3]), 64'(ref_mem[3]));
        samp();
        exp_wr.push_back({8'h0C, 32'hCAFEF00D});
        ref_mem[3] = 32'hCAFEF00D;
        reset_n = 1'b1;
        #1 check("t5 owner idle after reset", 64'(gnt0), 64'(0));
        tick();
        samp(); check("t5 regrant", 64'(gnt0), 64'(1));
        tick(); req0 = 0; wr0 = 0;
        samp(); check("t5 word written", 64'(dmem[3]), 64'(ref_mem[3]));

`ifdef DMEM_ARB_ALIGN_CHECK_EN
        // T6: misaligned write is consumed without touching memory
        do_reset();
        req0 = 1; wr0 = 1; addr0 = 8'h06; wdata0 = 32'h1234_5678;
        samp(); check("t6 gnt0 idle cycle", 64'(gnt0), 64'(0));
        samp(); check("t6 gnt0", 64'(gnt0), 64'(1));
        check("t6 mem_wr blocked", 64'(mem_wr), 64'(0));
        check("t6 err0 before", 64'(err0), 64'(0));
        tick(); req0 = 0; wr0 = 0;
        samp(); check("t6 err0 pulse", 64'(err0), 64'(1));
        check("t6 rvalid0", 64'(rvalid0), 64'(0));
        samp(); check("t6 err0 clear", 64'(err0), 64'(0));
        check("t6 word unchanged", 64'(dmem[1]), 64'(ref_mem[1]));
`endif

        repeat (3) samp();
        check("rd0 queue drained", 64'(exp_rd0.size()), 64'(0));
        check("rd1 queue drained", 64'(exp_rd1.size()), 64'(0));
        check("wr queue drained", 64'(exp_wr.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter sharing one single-port dmem (async read, write on posedge clock, byte address, word index = addr[AW-1:2]).
- Port 0 is the CPU load/store path; port 1 is a secondary master (DMA / display refresh).
- Sits between both masters and dmem. Drives dmem wr/addr/din and returns registered read data per port.
- Supports bounded locked bursts so one master cannot starve the other.

Parameters:
- Nloc, 64, number of dmem words; must match dmem.
- Dbits, 32, data width.
- MAXBURST, 4, maximum consecutive granted accesses to one owner while the other port waits; must be >= 1.
- AW (localparam), $clog2(Nloc)+2, byte address width.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1  access request; held with wr/addr/wdata stable until gnt.
- lock0, lock1  in  1  ask to keep ownership for the following access (burst).
- wr0, wr1  in  1  1 = write, 0 = read.
- addr0, addr1  in  AW  byte address.
- wdata0, wdata1  in  Dbits  write data.
- gnt0, gnt1  out  1  combinational; access is performed at the coming posedge.
- rdata0, rdata1  out  Dbits  registered read data, held until the next read on that port.
- rvalid0, rvalid1  out  1  one-cycle pulse the cycle after a granted read.
- mem_wr  out  1  to dmem wr.
- mem_addr  out  AW  to dmem addr.
- mem_din  out  Dbits  to dmem din.
- mem_dout  in  Dbits  from dmem dout.

Behaviour:
- State: owner ∈ {IDLE, OWN0, OWN1}; last (1 bit, last owner); burst_cnt ($clog2(MAXBURST+1) bits).
- Reset (async, reset_n=0):
  - owner=IDLE, last=1 (so port 0 wins the first tie), burst_cnt=0.
  - rdata*=0, rvalid*=0. gnt*=0 and mem_wr=0 immediately, so no write can occur while reset is asserted.
- Grant (combinational):
  - gnt_x = (owner==OWNx) & req_x.
  - mem_wr = gnt0&wr0 | gnt1&wr1.
  - mem_addr/mem_din muxed from port x when owner==OWNx, otherwise from port `last`.
- IDLE next state:
  - req0&req1: OWN to the port ≠ last.
  - Single request: OWN to that port.
  - No request: stay IDLE.
  - A request seen in IDLE is therefore granted 1 cycle later.
- OWNx next state (y = other port), first matching rule wins:
  1. req_y & (!req_x | !lock_x | burst_cnt==MAXBURST-1): go to OWNy, burst_cnt=0, last=x.
  2. req_x: stay OWNx, burst_cnt = min(burst_cnt+1, MAXBURST-1).
  3. Otherwise: go to IDLE, burst_cnt=0, last=x.
- Resulting behaviour:
  - An unlocked owner gets one access and then alternates with a waiting requester.
  - A sole requester streams back-to-back at 1 access/cycle.
- Read data:
  - On posedge with gnt_x & !wr_x: rdata_x <= mem_dout and rvalid_x <= 1.
  - Otherwise rvalid_x <= 0 and rdata_x holds.
- Address: bits [1:0] are ignored (word access), wrapping is as in dmem. Arbiter does no address arithmetic.
- Dropping req_x while OWNx (before gnt) is legal and follows rule 1 or 3.
- Changing wr/addr/wdata while req is high and not yet granted is illegal; the bench asserts against it.

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - Extra outputs err0/err1 (1 bit).
  - When gnt_x and addr_x[1:0]≠0: mem_wr forced 0, rvalid_x stays 0, and err_x pulses 1 the next cycle.
  - Handshake and arbitration are unchanged (access consumed).
- Undefined:
  - No err ports; low address bits are ignored silently.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t.
  - Port index constants P0=0, P1=1.
- Sub-module rr_pick2:
  - Combinational 2-way round-robin picker (req[1:0], last → winner, valid).
  - Used by both IDLE and handover decisions.

Test Plan:
- Reset then req0 only, write addr=8 data=0xDEADBEEF: gnt0 high the 2nd cycle, mem_wr=1, mem_addr=8. A later read of addr 8 gives rvalid0 one cycle after gnt0 with rdata0=0xDEADBEEF.
- req0 and req1 rise together after reset, unlocked: gnt0, gnt1, gnt0, gnt1 on consecutive cycles; last toggles each access.
- MAXBURST=4, req0+lock0 held, req1 raised on cycle 2: exactly 4 consecutive gnt0 cycles, then gnt1 and no further gnt0 until the switch back.
- req1 alone held for 10 cycles with lock1=0: gnt1 on 10 consecutive cycles (after 1-cycle IDLE latency); burst_cnt saturates at 3 with no handover.
- reset_n asserted mid-write, in a cycle with gnt0&wr0: mem_wr drops to 0 combinationally, memory word is unchanged, rvalid* are 0, owner is IDLE.
- With DMEM_ARB_ALIGN_CHECK_EN: write to addr=6 is granted, mem_wr=0, err0 pulses 1 the next cycle, and the memory word at index 1 is unchanged.
